// File: rtl/candy_sram_pkg.sv
// Shared types and defaults for the candy SRAM and its read pipeline.
package candy_sram_pkg;

  localparam logic RSTN_ENABLE  = 1'b0;
  localparam logic RSTN_DISABLE = 1'b1;

  localparam int unsigned SRAM_ADDR_WIDTH = 10;
  localparam int unsigned SRAM_DATA_WIDTH = 32;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } sram_state_e;

  function automatic int unsigned sram_strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/candy_sram_rdpipe.sv
// Valid+data delay line with asynchronous active-low flush; data holds while idle.
module candy_sram_rdpipe
  import candy_sram_pkg::*;
#(
  parameter int unsigned STAGES = 0,
  parameter int unsigned WIDTH  = SRAM_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data
);

  if (STAGES == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk ^ rst_n;
    assign dn_valid      = up_valid;
    assign dn_data       = up_data;
  end else begin : g_pipe
    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  d_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (rst_n == RSTN_ENABLE) begin
        v_q <= '0;
        for (int unsigned i = 0; i < STAGES; i++) d_q[i] <= '0;
      end else begin
        v_q[0] <= up_valid;
        if (up_valid) d_q[0] <= up_data;
        for (int unsigned i = 1; i < STAGES; i++) begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) d_q[i] <= d_q[i-1];
        end
      end
    end

    assign dn_valid = v_q[STAGES-1];
    assign dn_data  = d_q[STAGES-1];
  end

endmodule

// File: rtl/candy_sram.sv
// 1R1W SRAM with byte strobes, write-first forwarding, configurable read latency
// and an optional post-reset clear sequence.
module candy_sram
  import candy_sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = SRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = SRAM_DATA_WIDTH,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned RD_LATENCY     = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sram_re,
  input  logic [ADDR_WIDTH-1:0]   sram_raddr,
  output logic [DATA_WIDTH-1:0]   sram_rdata,
  output logic                    sram_rvalid,
  input  logic                    sram_we,
  input  logic [ADDR_WIDTH-1:0]   sram_waddr,
  input  logic [DATA_WIDTH-1:0]   sram_wdata,
  input  logic [DATA_WIDTH/8-1:0] sram_wstrb,
  output logic                    init_busy
);

  localparam int unsigned           STRB_W      = sram_strb_width(DATA_WIDTH);
  localparam int unsigned           IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
  localparam sram_state_e           RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clr_last, running;
  logic                  rd_in_range, wr_in_range, rd_accept, wr_accept;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [STRB_W-1:0]     mem_strb;
  logic [DATA_WIDTH-1:0] rd_word, rd_merged;
  logic                  s0_valid;
  logic [DATA_WIDTH-1:0] s0_data;

  assign running     = (state_q == S_RUN);
  assign clr_last    = (clr_cnt == LAST_ADDR);
  assign rd_in_range = ({1'b0, sram_raddr} < DEPTH_EXT);
  assign wr_in_range = ({1'b0, sram_waddr} < DEPTH_EXT);
  assign rd_accept   = running && sram_re;
  assign wr_accept   = running && sram_we && wr_in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      state_q <= RESET_STATE;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_CLEAR) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_CLEAR && clr_last) state_d = S_RUN;
  end

  always_comb begin
    init_busy = 1'b0;
    if (state_q == S_CLEAR) init_busy = 1'b1;
  end

  // The clear sequencer owns the single write port while it runs.
  always_comb begin
    mem_we    = wr_accept;
    mem_addr  = sram_waddr[IDX_W-1:0];
    mem_wdata = sram_wdata;
    mem_strb  = sram_wstrb;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_cnt[IDX_W-1:0];
      mem_wdata = '0;
      mem_strb  = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (mem_strb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Write-first: strobed lanes of a same-address write override the stored word.
  always_comb begin
    rd_word   = rd_in_range ? mem[sram_raddr[IDX_W-1:0]] : '0;
    rd_merged = rd_word;
    if (wr_accept && (sram_waddr == sram_raddr)) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (sram_wstrb[b]) rd_merged[8*b +: 8] = sram_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
    end else begin
      s0_valid <= rd_accept;
      if (rd_accept) s0_data <= rd_merged;
    end
  end

  candy_sram_rdpipe #(
    .STAGES (RD_LATENCY - 1),
    .WIDTH  (DATA_WIDTH)
  ) u_rdpipe (
    .clk      (clk),
    .rst_n    (rst),
    .up_valid (s0_valid),
    .up_data  (s0_data),
    .dn_valid (sram_rvalid),
    .dn_data  (sram_rdata)
  );

endmodule

// File: doc/candy_sram.md
Name: candy_sram

Overview:
- Parametrised behavioural/synthesisable 1R1W SRAM that serves the candy core's sram_raddr/sram_rdata and sram_waddr/sram_wdata ports.
- Successor to the fixed-width, zero-latency memory used by the candy bench.
- Adds configurable read latency, byte-strobe writes and write-first collision forwarding.
- Adds an optional post-reset clear sequencer, so core and bench see a defined memory image after every reset.

Parameters:
- ADDR_WIDTH, 10, address bits on both ports.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- DEPTH, 1024, implemented words; DEPTH <= 2**ADDR_WIDTH.
- RD_LATENCY, 1, cycles from read request to sram_rvalid; legal range 1..4.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents undefined, no clear phase.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- sram_re  in  1  read request.
- sram_raddr  in  ADDR_WIDTH  read address.
- sram_rdata  out  DATA_WIDTH  read data.
- sram_rvalid  out  1  one-cycle pulse per accepted read.
- sram_we  in  1  write request.
- sram_waddr  in  ADDR_WIDTH  write address.
- sram_wdata  in  DATA_WIDTH  write data.
- sram_wstrb  in  DATA_WIDTH/8  byte-lane enables; bit i covers bits [8i+7:8i].
- init_busy  out  1  high while the clear sequence runs; requests are not accepted.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- While rst=0:
  - sram_rdata=0, sram_rvalid=0, read pipeline flushed, clear counter=0.
  - init_busy=CLEAR_ON_RESET.
  - Array contents not touched by reset itself.
- FSM states: S_CLEAR, S_RUN.
  - Reset entry: S_CLEAR if CLEAR_ON_RESET=1, else S_RUN.
  - S_CLEAR: writes 0 to word clr_cnt each cycle, clr_cnt counts 0..DEPTH-1; init_busy=1.
  - S_CLEAR -> S_RUN: on the edge that writes DEPTH-1, so clear takes exactly DEPTH cycles; init_busy drops in the following cycle.
  - S_RUN: terminal until the next reset.
- Requests during S_CLEAR: reads produce no sram_rvalid; writes dropped. No queuing.
- Reset mid-clear: restarts the clear from address 0 after release.
- Read accept: sram_re=1 in S_RUN at a rising edge.
- Read response:
  - Word at sram_raddr appears on sram_rdata with sram_rvalid=1 exactly RD_LATENCY edges later.
  - Fully pipelined; one read per cycle sustained.
  - sram_rdata holds its last value while sram_rvalid=0.
- Write: sram_we=1 in S_RUN updates only the lanes with sram_wstrb=1 at that edge. sram_wstrb=0 is a legal no-op.
- Same-cycle read and write, same address (write-first):
  - Returned word = strobed lanes from sram_wdata, remaining lanes from the old word.
  - Read issued the cycle after a write always sees the new data.
- Out-of-range address (>= DEPTH):
  - Read returns 0 with normal sram_rvalid timing.
  - Write dropped, no aliasing.
- Latency pipeline: RD_LATENCY-1 registered stages after the array read. Each stage carries a valid bit and data.

Decomposition:
- candy_defines.v gains:
  - `RstnEnable 1'b0 / `RstnDisable 1'b1.
  - `SRAMStrbWidth.
  - state encodings `SramClear / `SramRun.
  - default ADDR/DATA width macros used as parameter defaults.
- One sub-module, candy_sram_rdpipe:
  - Parametrised valid+data delay line of depth RD_LATENCY-1 with async active-low flush.
  - Reused by other latency-configurable blocks.
- Top level holds the array, FSM, clear counter and collision merge.

Test Plan:
- Reset sequence, DEPTH=16, CLEAR_ON_RESET=1: release rst at t0 -> init_busy high 16 cycles, then low. Reading addresses 0..15 returns 0x00000000 each.
- Byte strobes, RD_LATENCY=1: write 0xAABBCCDD to 0x5 with wstrb=4'b1111, then 0x11223344 with wstrb=4'b0101 -> read 0x5 returns 0xAA22CC44, sram_rvalid one cycle after re.
- Back-to-back reads, RD_LATENCY=3: reads of addresses 1,2,3 on consecutive cycles (preloaded 0x10,0x20,0x30) -> rvalid on cycles 3,4,5 carrying 0x10,0x20,0x30.
- Collision: word 0x7 = 0x00000000; same-cycle write 0xDEADBEEF wstrb=4'b1100 and read of 0x7 -> returns 0xDEAD0000.
- Reset mid-clear, DEPTH=16: assert rst at clear cycle 8, release -> init_busy high a full 16 cycles again. Reads/writes issued during clear produce no rvalid and leave no data change.
- Out-of-range, DEPTH=12, ADDR_WIDTH=4: write 0xFFFFFFFF to 0xC, then read 0xC -> rdata 0, rvalid asserted. Word 0x0 still 0.
